cross_bar_scheduler_mxn: RTL
============================

Name: cross_bar_scheduler_mxn

Overview:
- Control-plane scheduler for the MxN AXI-Stream crossbar. Each input names its output through tdest.
- Per output, it arbitrates packet-level ownership among the requesting inputs using work-conserving round-robin.
- It drives the mux select and active flag for each output, and reports which inputs are connected.
- It watches each output's handshake to release ownership at end of packet. No datapath passes through it.

Parameters:
- MSEL_WIDTH, 2, input index width.
- M_CHANNEL_NO, 2**MSEL_WIDTH, number of inputs (2..2**MSEL_WIDTH).
- NSEL_WIDTH, 2, tdest / output index width.
- N_CHANNEL_NO, 2**NSEL_WIDTH, number of outputs (1..2**NSEL_WIDTH).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- s_axis_tvalid[M_CHANNEL_NO]  in  1  input has data.
- s_axis_tdest[M_CHANNEL_NO]  in  NSEL_WIDTH  requested output. Stable while tvalid is high and the input is ungranted.
- m_axis_tvalid[N_CHANNEL_NO]  in  1  crossbar output valid (observed).
- m_axis_tlast[N_CHANNEL_NO]  in  1  crossbar output last (observed).
- m_axis_tready[N_CHANNEL_NO]  in  1  downstream ready (observed).
- out_sel_bin[N_CHANNEL_NO]  out  MSEL_WIDTH  input routed to output j.
- out_sel_active[N_CHANNEL_NO]  out  1  output j owned by out_sel_bin[j].
- in_grant[M_CHANNEL_NO]  out  1  input i is connected to some output.
- dest_err[M_CHANNEL_NO]  out  1  sticky flag: input i presented tvalid with tdest >= N_CHANNEL_NO.

Behaviour:
- Reset: asserting aresetn low immediately clears the following, at any time including mid-packet.
  - All output FSMs go to IDLE.
  - out_sel_active=0, out_sel_bin=0, in_grant=0, dest_err=0.
  - All round-robin pointers ptr[j]=0.
- All outputs are registered. No combinational path from inputs to outputs.
- Request vector for output j: req_j[i] = s_axis_tvalid[i] & (s_axis_tdest[i]==j) & !in_grant[i].
  - An input targets exactly one output, so no cross-output conflict exists.
  - An input is never granted to two outputs.
- Per-output FSM, state IDLE:
  - Search req_j starting at index ptr[j], ascending, wrapping at M_CHANNEL_NO-1 -> 0. The first set bit wins.
  - On a winner w at edge t: state<=ACTIVE, out_sel_bin[j]<=w, out_sel_active[j]<=1, in_grant[w]<=1, ptr[j]<=(w+1) mod M_CHANNEL_NO.
  - Latency: a request present before edge t is granted and visible after edge t (1 cycle).
  - No requester: hold state, pointer unchanged. Unlike rotate-while-idle, the pointer moves only on a grant.
- Per-output FSM, state ACTIVE:
  - End of packet = m_axis_tvalid[j] & m_axis_tlast[j] & m_axis_tready[j] at an edge.
  - On end of packet: state<=IDLE, out_sel_active[j]<=0, in_grant[out_sel_bin[j]]<=0. out_sel_bin[j] holds its last value.
  - Otherwise hold, including tlast with tready=0 (backpressure) and any number of non-last beats.
  - tvalid dropping mid-packet does not release ownership.
- Inter-packet gap: after release at edge t, the output is IDLE for one cycle. The earliest regrant is edge t+1, visible the cycle after.
  - The released input sees in_grant=0 in that same IDLE cycle, so it can compete in the following arbitration.
- Independent outputs grant and release in the same cycle without interaction.
- tdest >= N_CHANNEL_NO (possible only when N_CHANNEL_NO < 2**NSEL_WIDTH):
  - The input is never granted.
  - dest_err[i] sets on the first such valid cycle and stays set until reset.
- Illegal encoded state: forces IDLE with out_sel_active=0 on the next edge.
- Width rules:
  - Pointer wrap uses an explicit compare against M_CHANNEL_NO-1, not natural overflow, to support non-power-of-2 M.
  - tdest comparison is done at NSEL_WIDTH bits.

Test Plan:
1. Reset release with all inputs idle -> every output reads 0 for 10 cycles; ptr behaviour shows first grant to input 0 when all request.
2. M=N=4: input 2 tvalid, tdest=1 before edge t -> after t, out_sel_active[1]=1, out_sel_bin[1]=2, in_grant[2]=1. Send 3 beats, tlast accepted at edge t+3 -> active[1]=0 and in_grant[2]=0 after t+3.
3. Inputs 0, 1, 3 continuously request output 0 with 2-beat packets -> grant sequence 0,1,3,0,1. Exactly one IDLE cycle between packets; input 2 never appears.
4. Input 0->out 2 and input 1->out 3 in the same cycle -> both granted on the same edge. Packet on out 2 ends while out 3 continues -> out 3 unaffected.
5. Output 1 owned: tvalid=1, tlast=1, tready=0 for 5 cycles -> ownership held. tready=1 -> released the next edge. Assert aresetn low mid-packet on output 0 -> active[0]=0 and in_grant=0 immediately, without waiting for a clock edge.
6. N_CHANNEL_NO=3, input 1 tvalid with tdest=3 -> dest_err[1]=1 after one edge, in_grant[1] stays 0. Other inputs are still scheduled normally.

Source files
------------

// File: rtl/cross_bar_scheduler_mxn.sv
// Control-plane scheduler for an MxN AXI-Stream crossbar. Each output owns one input
// per packet, chosen by pointer-based round-robin and released on the accepted tlast beat.
module cross_bar_scheduler_mxn #(
  parameter int MSEL_WIDTH   = 2,
  parameter int M_CHANNEL_NO = 2**MSEL_WIDTH,
  parameter int NSEL_WIDTH   = 2,
  parameter int N_CHANNEL_NO = 2**NSEL_WIDTH
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid  [M_CHANNEL_NO],
  input  logic [NSEL_WIDTH-1:0] s_axis_tdest   [M_CHANNEL_NO],
  input  logic                  m_axis_tvalid  [N_CHANNEL_NO],
  input  logic                  m_axis_tlast   [N_CHANNEL_NO],
  input  logic                  m_axis_tready  [N_CHANNEL_NO],
  output logic [MSEL_WIDTH-1:0] out_sel_bin    [N_CHANNEL_NO],
  output logic                  out_sel_active [N_CHANNEL_NO],
  output logic                  in_grant       [M_CHANNEL_NO],
  output logic                  dest_err       [M_CHANNEL_NO]
);
  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_ACTIVE = 2'b01} state_t;

  localparam logic [MSEL_WIDTH-1:0] LAST_IN = MSEL_WIDTH'(M_CHANNEL_NO - 1);
  localparam logic [NSEL_WIDTH:0]   N_LIMIT = (NSEL_WIDTH + 1)'(N_CHANNEL_NO);

  state_t                  state_r          [N_CHANNEL_NO];
  state_t                  state_nxt_s      [N_CHANNEL_NO];
  logic [MSEL_WIDTH-1:0]   ptr_r            [N_CHANNEL_NO];
  logic [MSEL_WIDTH-1:0]   ptr_nxt_s        [N_CHANNEL_NO];
  logic [MSEL_WIDTH-1:0]   sel_bin_r        [N_CHANNEL_NO];
  logic [MSEL_WIDTH-1:0]   sel_bin_nxt_s    [N_CHANNEL_NO];
  logic                    sel_active_r     [N_CHANNEL_NO];
  logic                    sel_active_nxt_s [N_CHANNEL_NO];
  logic                    in_grant_r       [M_CHANNEL_NO];
  logic                    in_grant_nxt_s   [M_CHANNEL_NO];
  logic                    dest_err_r       [M_CHANNEL_NO];
  logic                    dest_err_nxt_s   [M_CHANNEL_NO];
  logic [M_CHANNEL_NO-1:0] req_s            [N_CHANNEL_NO];
  logic [MSEL_WIDTH:0]     pick_s           [N_CHANNEL_NO];
  logic                    eop_s            [N_CHANNEL_NO];

  // Explicit wrap keeps non-power-of-2 input counts inside range
  function automatic logic [MSEL_WIDTH-1:0] ptr_inc(input logic [MSEL_WIDTH-1:0] idx);
    return (idx == LAST_IN) ? {MSEL_WIDTH{1'b0}} : idx + MSEL_WIDTH'(1);
  endfunction

  // Returns {found, winner}: first set request at or after ptr, wrapping
  function automatic logic [MSEL_WIDTH:0] rr_pick(input logic [M_CHANNEL_NO-1:0] req,
                                                   input logic [MSEL_WIDTH-1:0]   ptr);
    logic [MSEL_WIDTH-1:0] idx;
    logic [MSEL_WIDTH-1:0] win;
    logic                  found;
    idx   = ptr;
    win   = {MSEL_WIDTH{1'b0}};
    found = 1'b0;
    for (int k = 0; k < M_CHANNEL_NO; k++) begin
      win   = (!found && req[idx]) ? idx : win;
      found = found | req[idx];
      idx   = ptr_inc(idx);
    end
    return {found, win};
  endfunction

  // Per-output request vectors, round-robin winners and end-of-packet detect
  always_comb begin
    for (int j = 0; j < N_CHANNEL_NO; j++) begin
      for (int i = 0; i < M_CHANNEL_NO; i++) begin
        req_s[j][i] = s_axis_tvalid[i] & (s_axis_tdest[i] == NSEL_WIDTH'(j)) & ~in_grant_r[i];
      end
      pick_s[j] = rr_pick(req_s[j], ptr_r[j]);
      eop_s[j]  = m_axis_tvalid[j] & m_axis_tlast[j] & m_axis_tready[j];
    end
  end

  // Next-state for ownership FSMs, grants and sticky destination errors
  always_comb begin
    for (int i = 0; i < M_CHANNEL_NO; i++) begin
      in_grant_nxt_s[i] = in_grant_r[i];
      dest_err_nxt_s[i] = dest_err_r[i] |
                          (s_axis_tvalid[i] & ({1'b0, s_axis_tdest[i]} >= N_LIMIT));
    end
    for (int j = 0; j < N_CHANNEL_NO; j++) begin
      state_nxt_s[j]      = state_r[j];
      ptr_nxt_s[j]        = ptr_r[j];
      sel_bin_nxt_s[j]    = sel_bin_r[j];
      sel_active_nxt_s[j] = sel_active_r[j];
      case (state_r[j])
        ST_IDLE: begin
          if (pick_s[j][MSEL_WIDTH]) begin
            state_nxt_s[j]      = ST_ACTIVE;
            sel_bin_nxt_s[j]    = pick_s[j][MSEL_WIDTH-1:0];
            sel_active_nxt_s[j] = 1'b1;
            ptr_nxt_s[j]        = ptr_inc(pick_s[j][MSEL_WIDTH-1:0]);
            in_grant_nxt_s[pick_s[j][MSEL_WIDTH-1:0]] = 1'b1;
          end else begin
            sel_active_nxt_s[j] = 1'b0;
          end
        end
        ST_ACTIVE: begin
          if (eop_s[j]) begin
            state_nxt_s[j]      = ST_IDLE;
            sel_active_nxt_s[j] = 1'b0;
            in_grant_nxt_s[sel_bin_r[j]] = 1'b0;
          end else begin
            sel_active_nxt_s[j] = 1'b1;
          end
        end
        default: begin
          // Corrupted state: drop ownership, freeing the input only if this output held it
          state_nxt_s[j]      = ST_IDLE;
          sel_active_nxt_s[j] = 1'b0;
          if (sel_active_r[j]) begin
            in_grant_nxt_s[sel_bin_r[j]] = 1'b0;
          end else begin
            in_grant_nxt_s[sel_bin_r[j]] = in_grant_nxt_s[sel_bin_r[j]];
          end
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int j = 0; j < N_CHANNEL_NO; j++) begin
        state_r[j]      <= ST_IDLE;
        ptr_r[j]        <= {MSEL_WIDTH{1'b0}};
        sel_bin_r[j]    <= {MSEL_WIDTH{1'b0}};
        sel_active_r[j] <= 1'b0;
      end
      for (int i = 0; i < M_CHANNEL_NO; i++) begin
        in_grant_r[i] <= 1'b0;
        dest_err_r[i] <= 1'b0;
      end
    end else begin
      for (int j = 0; j < N_CHANNEL_NO; j++) begin
        state_r[j]      <= state_nxt_s[j];
        ptr_r[j]        <= ptr_nxt_s[j];
        sel_bin_r[j]    <= sel_bin_nxt_s[j];
        sel_active_r[j] <= sel_active_nxt_s[j];
      end
      for (int i = 0; i < M_CHANNEL_NO; i++) begin
        in_grant_r[i] <= in_grant_nxt_s[i];
        dest_err_r[i] <= dest_err_nxt_s[i];
      end
    end
  end

  assign out_sel_bin    = sel_bin_r;
  assign out_sel_active = sel_active_r;
  assign in_grant       = in_grant_r;
  assign dest_err       = dest_err_r;

endmodule
